// File: rtl/arb_pkg.sv
// Shared types for the GEMM/CPU memory arbiter: ownership tag and memory command bus.
// No logic, no latency.
// No flow control; types only.
package arb_pkg;

    localparam int LINE_BYTES = 16;
    localparam int LANES      = 4;
    localparam int CTRL_W     = 5;
    localparam int ADDR_BITS  = 32;
    localparam int LINE_BITS  = LINE_BYTES * 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_GEMM = 2'd2
    } owner_e;

    typedef struct packed {
        logic                  rdwr;
        logic [ADDR_BITS-1:0]  addr;
        logic [LINE_BITS-1:0]  wr_data;
        logic [LINE_BYTES-1:0] byte_en;
        logic [CTRL_W-1:0]     control;
    } mem_cmd_t;

endpackage

// File: rtl/cpu_lane_steer.sv
// Steers a 32-bit CPU word into a 128-bit line (write) and selects it back out (read).
// Purely combinational, zero latency.
// No flow control; follows whatever the arbiter grants.
module cpu_lane_steer
    import arb_pkg::*;
(
    input  logic [31:0]           wr_word,
    input  logic [3:0]            wr_mask,
    input  logic [1:0]            wr_lane,
    output logic [LINE_BITS-1:0]  wr_line,
    output logic [LINE_BYTES-1:0] byte_en,
    input  logic [LINE_BITS-1:0]  rd_line,
    input  logic [1:0]            rd_lane,
    output logic [31:0]           rd_word
);

    // Every lane carries the word; byte enables decide which lane lands.
    assign wr_line = {LANES{wr_word}};
    assign byte_en = {{(LINE_BYTES-4){1'b0}}, wr_mask} << {wr_lane, 2'b00};
    assign rd_word = rd_line[{rd_lane, 5'b00000} +: 32];

endmodule

// File: rtl/gemm_mem_arbiter.sv
// Per-cycle arbiter sharing one 128-bit single-port memory between CPU words and GEMM lines.
// Grant is same-cycle; read data returns to the owner one cycle after its grant.
// Requesters hold req until gnt; GEMM wins contention for a bounded streak, then CPU is forced in.
module gemm_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W          = ADDR_BITS,
    parameter int LINE_W          = LINE_BITS,
    parameter int MAX_GEMM_STREAK = 8,
    parameter int STALL_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_rdwr,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [31:0]           cpu_wr_data,
    input  logic [3:0]            cpu_mask,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [31:0]           cpu_rd_data,
    input  logic                  gemm_req,
    input  logic                  gemm_rdwr,
    input  logic [ADDR_W-1:0]     gemm_addr,
    input  logic [LINE_W-1:0]     gemm_wr_data,
    input  logic [CTRL_W-1:0]     gemm_control,
    output logic                  gemm_gnt,
    output logic                  gemm_rvalid,
    output logic [LINE_W-1:0]     gemm_rd_data,
    output logic                  mem_en,
    output logic                  mem_rdwr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [LINE_W-1:0]     mem_wr_data,
    output logic [LINE_BYTES-1:0] mem_byte_en,
    output logic [CTRL_W-1:0]     mem_control,
    input  logic [LINE_W-1:0]     mem_rd_data,
    output logic [STALL_W-1:0]    cpu_stall_cnt
);

    localparam int STREAK_W = $clog2(MAX_GEMM_STREAK + 1);

    logic                  arb_en;
    logic [STREAK_W-1:0]   streak;
    logic                  streak_full;
    owner_e                rsp_tag;
    logic [1:0]            rsp_lane;
    logic [31:0]           cpu_rd_q;
    logic [31:0]           cpu_rd_word;
    logic [LINE_W-1:0]     gemm_rd_q;
    logic [LINE_W-1:0]     cpu_wr_line;
    logic [LINE_BYTES-1:0] cpu_byte_en;
    mem_cmd_t              cmd;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{cpu_addr[1:0], gemm_addr[3:0]};

    // arb_en keeps every grant low while reset is asserted without using rst as data.
    assign streak_full = (streak >= STREAK_W'(MAX_GEMM_STREAK));
    assign cpu_gnt     = arb_en & cpu_req & (~gemm_req | streak_full);
    assign gemm_gnt    = arb_en & gemm_req & ~cpu_gnt;
    assign mem_en      = cpu_gnt | gemm_gnt;

    cpu_lane_steer u_steer (
        .wr_word (cpu_wr_data),
        .wr_mask (cpu_mask),
        .wr_lane (cpu_addr[3:2]),
        .wr_line (cpu_wr_line),
        .byte_en (cpu_byte_en),
        .rd_line (mem_rd_data),
        .rd_lane (rsp_lane),
        .rd_word (cpu_rd_word)
    );

    always_comb begin
        cmd = '0;
        if (cpu_gnt) begin
            cmd.rdwr = cpu_rdwr;
            cmd.addr = {cpu_addr[ADDR_W-1:4], 4'b0000};
            if (cpu_rdwr) begin
                cmd.wr_data = cpu_wr_line;
                cmd.byte_en = cpu_byte_en;
            end
        end else if (gemm_gnt) begin
            cmd.rdwr    = gemm_rdwr;
            cmd.addr    = {gemm_addr[ADDR_W-1:4], 4'b0000};
            cmd.wr_data = gemm_wr_data;
            cmd.byte_en = '1;
            cmd.control = gemm_control;
        end
    end

    assign mem_rdwr    = cmd.rdwr;
    assign mem_addr    = cmd.addr;
    assign mem_wr_data = cmd.wr_data;
    assign mem_byte_en = cmd.byte_en;
    assign mem_control = cmd.control;

    // Read data bypasses straight from memory in the response cycle, then holds.
    assign cpu_rvalid   = (rsp_tag == OWN_CPU);
    assign gemm_rvalid  = (rsp_tag == OWN_GEMM);
    assign cpu_rd_data  = cpu_rvalid  ? cpu_rd_word : cpu_rd_q;
    assign gemm_rd_data = gemm_rvalid ? mem_rd_data : gemm_rd_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arb_en        <= 1'b0;
            streak        <= '0;
            rsp_tag       <= OWN_NONE;
            rsp_lane      <= 2'b00;
            cpu_rd_q      <= '0;
            gemm_rd_q     <= '0;
            cpu_stall_cnt <= '0;
        end else begin
            arb_en <= 1'b1;

            if (cpu_gnt || !cpu_req) begin
                streak <= '0;
            end else if (gemm_gnt && !streak_full) begin
                streak <= streak + 1'b1;
            end

            if (cpu_gnt && !cpu_rdwr) begin
                rsp_tag  <= OWN_CPU;
                rsp_lane <= cpu_addr[3:2];
            end else if (gemm_gnt && !gemm_rdwr) begin
                rsp_tag <= OWN_GEMM;
            end else begin
                rsp_tag <= OWN_NONE;
            end

            if (cpu_rvalid) cpu_rd_q <= cpu_rd_word;
            if (gemm_rvalid) gemm_rd_q <= mem_rd_data;

            if (cpu_req && !cpu_gnt && (cpu_stall_cnt != '1)) begin
                cpu_stall_cnt <= cpu_stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gemm_mem_arbiter.sv
// Randomised self-checking bench for gemm_mem_arbiter with a behavioural memory and golden line store.
module tb_gemm_mem_arbiter;

    localparam int MAXS = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req, cpu_rdwr;
    logic [31:0]  cpu_addr, cpu_wr_data;
    logic [3:0]   cpu_mask;
    logic         cpu_gnt, cpu_rvalid;
    logic [31:0]  cpu_rd_data;
    logic         gemm_req, gemm_rdwr;
    logic [31:0]  gemm_addr;
    logic [127:0] gemm_wr_data;
    logic [4:0]   gemm_control;
    logic         gemm_gnt, gemm_rvalid;
    logic [127:0] gemm_rd_data;
    logic         mem_en, mem_rdwr;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wr_data;
    logic [15:0]  mem_byte_en;
    logic [4:0]   mem_control;
    logic [127:0] mem_rd_data;
    logic [15:0]  cpu_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] ref_mem [256];
    logic [127:0] mem_arr [256];

    always #5 clk = ~clk;

    gemm_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_rdwr(cpu_rdwr), .cpu_addr(cpu_addr),
        .cpu_wr_data(cpu_wr_data), .cpu_mask(cpu_mask), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rd_data(cpu_rd_data),
        .gemm_req(gemm_req), .gemm_rdwr(gemm_rdwr), .gemm_addr(gemm_addr),
        .gemm_wr_data(gemm_wr_data), .gemm_control(gemm_control), .gemm_gnt(gemm_gnt),
        .gemm_rvalid(gemm_rvalid), .gemm_rd_data(gemm_rd_data),
        .mem_en(mem_en), .mem_rdwr(mem_rdwr), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_byte_en(mem_byte_en), .mem_control(mem_control),
        .mem_rd_data(mem_rd_data), .cpu_stall_cnt(cpu_stall_cnt)
    );

    function automatic logic [127:0] init_line(input int i);
        logic [31:0] k;
        k = 32'(i);
        return {k * 32'h9E3779B1, k ^ 32'hA5A50000, k * 32'h01010101 + 32'h1357, ~k};
    endfunction

    // Single-port memory: command captured mid-cycle, applied on the rising edge.
    initial begin
        logic         c_en, c_rdwr;
        logic [7:0]   c_idx;
        logic [127:0] c_wdat, line;
        logic [15:0]  c_be;
        for (int i = 0; i < 256; i++) mem_arr[i] = init_line(i);
        mem_rd_data <= '0;
        forever begin
            @(negedge clk);
            c_en = mem_en; c_rdwr = mem_rdwr; c_idx = mem_addr[11:4];
            c_wdat = mem_wr_data; c_be = mem_byte_en;
            @(posedge clk);
            if (c_en) begin
                if (c_rdwr) begin
                    line = mem_arr[c_idx];
                    for (int b = 0; b < 16; b++)
                        if (c_be[b]) line[8*b +: 8] = c_wdat[8*b +: 8];
                    mem_arr[c_idx] = line;
                end else begin
                    mem_rd_data <= mem_arr[c_idx];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] exp_cpu_be(input logic [3:0] m, input logic [1:0] lane);
        logic [15:0] be;
        be = '0;
        for (int b = 0; b < 4; b++) be[4*lane + b] = m[b];
        return be;
    endfunction

    task automatic ref_cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        for (int b = 0; b < 4; b++)
            if (m[b]) ref_mem[a[11:4]][32*a[3:2] + 8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic ref_gemm_write(input logic [31:0] a, input logic [127:0] line);
        ref_mem[a[11:4]] = line;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_rdwr = 0; cpu_addr = '0; cpu_wr_data = '0; cpu_mask = '0;
        gemm_req = 0; gemm_rdwr = 0; gemm_addr = '0; gemm_wr_data = '0; gemm_control = '0;
    endtask

    task automatic next_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        next_slot();
        next_slot();
        rst = 1;
        next_slot();
    endtask

    task automatic test_reset();
        rst = 0;
        cpu_req = 1; cpu_rdwr = 1; cpu_addr = $urandom; cpu_wr_data = $urandom; cpu_mask = 4'hF;
        gemm_req = 1; gemm_rdwr = 0; gemm_addr = $urandom;
        gemm_wr_data = {$urandom, $urandom, $urandom, $urandom}; gemm_control = 5'd7;
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, gemm_gnt, mem_en} !== 3'b000) begin
            n_fail++; $display("FAIL reset_gnt: got %b want 000", {cpu_gnt, gemm_gnt, mem_en});
        end
        n_checks++;
        if ({mem_rdwr, mem_addr, mem_wr_data, mem_byte_en, mem_control} !== '0) begin
            n_fail++; $display("FAIL reset_membus: got addr=%h be=%h ctl=%h want all 0", mem_addr, mem_byte_en, mem_control);
        end
        n_checks++;
        if ({cpu_rvalid, gemm_rvalid, cpu_rd_data, gemm_rd_data} !== '0) begin
            n_fail++; $display("FAIL reset_rsp: got rv=%b%b cpu=%h gemm=%h want 0", cpu_rvalid, gemm_rvalid, cpu_rd_data, gemm_rd_data);
        end
        n_checks++;
        if (cpu_stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_stall: got %0d want 0", cpu_stall_cnt);
        end
        idle();
        next_slot();
        rst = 1;
        next_slot();
    endtask

    task automatic test_cpu_write();
        cpu_req = 1; cpu_rdwr = 1; cpu_addr = 32'h104; cpu_wr_data = 32'hDEADBEEF; cpu_mask = 4'b0011;
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, gemm_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL cpu_wr_gnt: got %b want 10", {cpu_gnt, gemm_gnt});
        end
        n_checks++;
        if (mem_byte_en !== 16'h0030) begin
            n_fail++; $display("FAIL cpu_wr_be: got %h want 0030", mem_byte_en);
        end
        n_checks++;
        if (mem_wr_data !== {4{32'hDEADBEEF}}) begin
            n_fail++; $display("FAIL cpu_wr_data: got %h want 4x deadbeef", mem_wr_data);
        end
        n_checks++;
        if ({mem_en, mem_rdwr, mem_addr} !== {1'b1, 1'b1, 32'h100}) begin
            n_fail++; $display("FAIL cpu_wr_cmd: got en=%b rdwr=%b addr=%h want 1 1 00000100", mem_en, mem_rdwr, mem_addr);
        end
        ref_cpu_write(32'h104, 32'hDEADBEEF, 4'b0011);
        next_slot();
        idle();
        @(negedge clk);
        n_checks++;
        if ({cpu_rvalid, gemm_rvalid} !== 2'b00) begin
            n_fail++; $display("FAIL cpu_wr_norsp: got rvalid %b want 00", {cpu_rvalid, gemm_rvalid});
        end
        next_slot();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_rdwr = 1; cpu_addr = 32'h10C; cpu_wr_data = 32'h12345678; cpu_mask = 4'hF;
        @(negedge clk);
        ref_cpu_write(32'h10C, 32'h12345678, 4'hF);
        next_slot();
        cpu_rdwr = 0; cpu_wr_data = $urandom;
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, mem_rdwr, mem_byte_en} !== {1'b1, 1'b0, 16'h0}) begin
            n_fail++; $display("FAIL cpu_rd_cmd: got gnt=%b rdwr=%b be=%h want 1 0 0000", cpu_gnt, mem_rdwr, mem_byte_en);
        end
        next_slot();
        idle();
        @(negedge clk);
        n_checks++;
        if ({cpu_rvalid, gemm_rvalid} !== 2'b10) begin
            n_fail++; $display("FAIL cpu_rd_rvalid: got %b want 10", {cpu_rvalid, gemm_rvalid});
        end
        n_checks++;
        if (cpu_rd_data !== 32'h12345678) begin
            n_fail++; $display("FAIL cpu_rd_data: got %h want 12345678", cpu_rd_data);
        end
        next_slot();
        @(negedge clk);
        n_checks++;
        if ({cpu_rvalid, cpu_rd_data} !== {1'b0, 32'h12345678}) begin
            n_fail++; $display("FAIL cpu_rd_hold: got rv=%b data=%h want 0 12345678", cpu_rvalid, cpu_rd_data);
        end
        next_slot();
    endtask

    task automatic test_gemm_control();
        logic [127:0] line;
        logic [31:0]  word;
        line = {$urandom, $urandom, $urandom, $urandom};
        word = $urandom;
        gemm_req = 1; gemm_rdwr = 1; gemm_addr = 32'h70 | 32'($urandom_range(0, 15));
        gemm_wr_data = line; gemm_control = 5'd3;
        @(negedge clk);
        n_checks++;
        if ({gemm_gnt, cpu_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL gemm_wr_gnt: got gemm/cpu=%b want 10", {gemm_gnt, cpu_gnt});
        end
        n_checks++;
        if ({mem_control, mem_byte_en} !== {5'd3, 16'hFFFF}) begin
            n_fail++; $display("FAIL gemm_wr_ctl: got ctl=%0d be=%h want 3 ffff", mem_control, mem_byte_en);
        end
        n_checks++;
        if ({mem_addr, mem_wr_data} !== {32'h70, line}) begin
            n_fail++; $display("FAIL gemm_wr_bus: got addr=%h data=%h want 00000070 %h", mem_addr, mem_wr_data, line);
        end
        ref_gemm_write(32'h70, line);
        next_slot();
        idle();
        cpu_req = 1; cpu_rdwr = 1; cpu_addr = 32'h78; cpu_wr_data = word; cpu_mask = 4'hF;
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, mem_control} !== {1'b1, 5'd0}) begin
            n_fail++; $display("FAIL cpu_after_gemm_ctl: got gnt=%b ctl=%0d want 1 0", cpu_gnt, mem_control);
        end
        ref_cpu_write(32'h78, word, 4'hF);
        next_slot();
        idle();
    endtask

    task automatic test_streak();
        logic exp_cpu;
        do_reset();
        cpu_req = 1; cpu_rdwr = 1; cpu_addr = 32'h200; cpu_wr_data = $urandom; cpu_mask = 4'hF;
        gemm_req = 1; gemm_rdwr = 1; gemm_addr = 32'h300;
        gemm_wr_data = {$urandom, $urandom, $urandom, $urandom}; gemm_control = 5'd0;
        for (int i = 0; i < 20; i++) begin
            exp_cpu = ((i % (MAXS + 1)) == MAXS);
            @(negedge clk);
            n_checks++;
            if ({cpu_gnt, gemm_gnt} !== {exp_cpu, ~exp_cpu}) begin
                n_fail++; $display("FAIL streak_gnt[%0d]: got cpu/gemm=%b want %b", i, {cpu_gnt, gemm_gnt}, {exp_cpu, ~exp_cpu});
            end
            if (exp_cpu) ref_cpu_write(cpu_addr, cpu_wr_data, cpu_mask);
            else ref_gemm_write(gemm_addr, gemm_wr_data);
            if (i == 2 * MAXS + 2) begin
                n_checks++;
                if (cpu_stall_cnt !== 16'd16) begin
                    n_fail++; $display("FAIL streak_stall: got %0d want 16", cpu_stall_cnt);
                end
            end
            next_slot();
        end
        idle();
    endtask

    task automatic test_alternating();
        logic         p_cpu, p_gemm;
        logic [31:0]  p_cpu_d, last_cpu;
        logic [127:0] p_gemm_d, last_gemm;
        logic [7:0]   idx;
        logic [1:0]   lane;
        logic [31:0]  exp_c;
        logic [127:0] exp_g;
        do_reset();
        p_cpu = 0; p_gemm = 0; p_cpu_d = '0; p_gemm_d = '0; last_cpu = '0; last_gemm = '0;
        for (int i = 0; i <= 16; i++) begin
            idle();
            idx = 8'($urandom); lane = 2'($urandom);
            if (i < 16) begin
                if (i % 2 == 0) begin
                    cpu_req = 1; cpu_addr = {20'h0, idx, lane, 2'b00};
                end else begin
                    gemm_req = 1; gemm_addr = {20'h0, idx, 4'($urandom)};
                end
            end
            @(negedge clk);
            if (i < 16) begin
                n_checks++;
                if ({cpu_gnt, gemm_gnt} !== {i % 2 == 0, i % 2 == 1}) begin
                    n_fail++; $display("FAIL alt_gnt[%0d]: got cpu/gemm=%b", i, {cpu_gnt, gemm_gnt});
                end
            end
            n_checks++;
            if ({cpu_rvalid, gemm_rvalid} !== {p_cpu, p_gemm}) begin
                n_fail++; $display("FAIL alt_rvalid[%0d]: got %b want %b", i, {cpu_rvalid, gemm_rvalid}, {p_cpu, p_gemm});
            end
            exp_c = p_cpu ? p_cpu_d : last_cpu;
            exp_g = p_gemm ? p_gemm_d : last_gemm;
            n_checks++;
            if (cpu_rd_data !== exp_c) begin
                n_fail++; $display("FAIL alt_cpu_data[%0d]: got %h want %h", i, cpu_rd_data, exp_c);
            end
            n_checks++;
            if (gemm_rd_data !== exp_g) begin
                n_fail++; $display("FAIL alt_gemm_data[%0d]: got %h want %h", i, gemm_rd_data, exp_g);
            end
            last_cpu = exp_c; last_gemm = exp_g;
            p_cpu  = (i < 16) && (i % 2 == 0);
            p_gemm = (i < 16) && (i % 2 == 1);
            p_cpu_d  = ref_mem[idx][32*lane +: 32];
            p_gemm_d = ref_mem[idx];
            next_slot();
        end
    endtask

    task automatic test_random();
        logic         c_act, c_rdwr, g_act, g_rdwr, c_was;
        logic [31:0]  c_addr, c_data, g_addr;
        logic [3:0]   c_mask;
        logic [127:0] g_data;
        logic [4:0]   g_ctl;
        logic         exp_c, exp_g;
        logic         p_cpu, p_gemm, n_cpu, n_gemm;
        logic [31:0]  p_cpu_d, n_cpu_d, last_cpu;
        logic [127:0] p_gemm_d, n_gemm_d, last_gemm;
        logic [15:0]  exp_be;
        int           run, stall_m;
        do_reset();
        c_act = 0; g_act = 0; c_rdwr = 0; g_rdwr = 0; c_addr = '0; c_data = '0; c_mask = '0;
        g_addr = '0; g_data = '0; g_ctl = '0;
        p_cpu = 0; p_gemm = 0; p_cpu_d = '0; p_gemm_d = '0; last_cpu = '0; last_gemm = '0;
        n_cpu_d = '0; n_gemm_d = '0;
        run = 0; stall_m = 0;
        for (int i = 0; i < 400; i++) begin
            if (!c_act && $urandom_range(0, 2) != 0) begin
                c_act = 1; c_rdwr = 1'($urandom); c_addr = {20'h0, 8'($urandom), 2'($urandom), 2'b00};
                c_data = $urandom; c_mask = 4'($urandom);
            end
            if (!g_act && $urandom_range(0, 3) != 0) begin
                g_act = 1; g_rdwr = 1'($urandom); g_addr = {20'h0, 8'($urandom), 4'($urandom)};
                g_data = {$urandom, $urandom, $urandom, $urandom}; g_ctl = 5'($urandom);
            end
            cpu_req = c_act; cpu_rdwr = c_rdwr; cpu_addr = c_addr; cpu_wr_data = c_data; cpu_mask = c_mask;
            gemm_req = g_act; gemm_rdwr = g_rdwr; gemm_addr = g_addr; gemm_wr_data = g_data; gemm_control = g_ctl;
            // Contention: GEMM keeps winning until it has taken MAXS grants in a row over a waiting CPU.
            if (c_act && g_act) begin
                exp_g = (run < MAXS); exp_c = ~exp_g;
            end else begin
                exp_c = c_act; exp_g = g_act;
            end
            @(negedge clk);
            n_checks++;
            if ({cpu_gnt, gemm_gnt} !== {exp_c, exp_g}) begin
                n_fail++; $display("FAIL rnd_gnt[%0d]: got cpu/gemm=%b want %b", i, {cpu_gnt, gemm_gnt}, {exp_c, exp_g});
            end
            if (exp_c || exp_g) begin
                exp_be = exp_g ? 16'hFFFF : (c_rdwr ? exp_cpu_be(c_mask, c_addr[3:2]) : 16'h0);
                n_checks++;
                if ({mem_byte_en, mem_control, mem_addr[31:4], mem_addr[3:0]} !==
                    {exp_be, (exp_g ? g_ctl : 5'd0), (exp_g ? g_addr[31:4] : c_addr[31:4]), 4'h0}) begin
                    n_fail++; $display("FAIL rnd_cmd[%0d]: got be=%h ctl=%0d addr=%h want be=%h", i, mem_byte_en, mem_control, mem_addr, exp_be);
                end
            end
            n_checks++;
            if ({cpu_rvalid, gemm_rvalid} !== {p_cpu, p_gemm}) begin
                n_fail++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", i, {cpu_rvalid, gemm_rvalid}, {p_cpu, p_gemm});
            end
            if (p_cpu) last_cpu = p_cpu_d;
            if (p_gemm) last_gemm = p_gemm_d;
            n_checks++;
            if ({cpu_rd_data, gemm_rd_data} !== {last_cpu, last_gemm}) begin
                n_fail++; $display("FAIL rnd_data[%0d]: got cpu=%h gemm=%h want cpu=%h gemm=%h", i, cpu_rd_data, gemm_rd_data, last_cpu, last_gemm);
            end
            n_cpu = 0; n_gemm = 0;
            c_was = c_act;
            if (c_was && !exp_c) stall_m++;
            if (c_was && exp_g) run++;
            else run = 0;
            if (exp_c) begin
                if (c_rdwr) ref_cpu_write(c_addr, c_data, c_mask);
                else begin
                    n_cpu = 1; n_cpu_d = ref_mem[c_addr[11:4]][32*c_addr[3:2] +: 32];
                end
                c_act = 0;
            end
            if (exp_g) begin
                if (g_rdwr) ref_gemm_write(g_addr, g_data);
                else begin
                    n_gemm = 1; n_gemm_d = ref_mem[g_addr[11:4]];
                end
                g_act = 0;
            end
            p_cpu = n_cpu; p_gemm = n_gemm; p_cpu_d = n_cpu_d; p_gemm_d = n_gemm_d;
            next_slot();
        end
        idle();
        @(negedge clk);
        n_checks++;
        if (cpu_stall_cnt !== 16'(stall_m)) begin
            n_fail++; $display("FAIL rnd_stall: got %0d want %0d", cpu_stall_cnt, stall_m);
        end
        next_slot();
    endtask

    task automatic test_reset_inflight();
        idle();
        gemm_req = 1; gemm_rdwr = 0; gemm_addr = 32'h50;
        @(negedge clk);
        n_checks++;
        if (gemm_gnt !== 1'b1) begin
            n_fail++; $display("FAIL inflight_gnt: got %b want 1", gemm_gnt);
        end
        next_slot();
        rst = 0;
        idle();
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, gemm_gnt, mem_en, cpu_rvalid, gemm_rvalid, gemm_rd_data} !== '0) begin
            n_fail++; $display("FAIL inflight_reset: got gnt=%b%b en=%b rv=%b%b data=%h want all 0",
                               cpu_gnt, gemm_gnt, mem_en, cpu_rvalid, gemm_rvalid, gemm_rd_data);
        end
        next_slot();
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (gemm_rvalid !== 1'b0) begin
                n_fail++; $display("FAIL inflight_rvalid[%0d]: got %b want 0", i, gemm_rvalid);
            end
            next_slot();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_line(i);
        do_reset();
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_gemm_control();
        test_streak();
        test_alternating();
        test_random();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
